imem_fetch_ctrl: RTL and testbench

//  Sequences the combinational instruction ROM for the RV32I core: owns the PC,

---
 rtl/rv32i_fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/imem_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch path.
// Used by fetch_fifo and imem_fetch_ctrl.
package rv32i_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_TRAP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs with a flush that
// empties it at the next edge; flush overrides push and pop.
module fetch_fifo
    import rv32i_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide
    // which slots are meaningful, so resetting the array only costs flops.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the combinational ROM
// and queues {pc, instr} for decode. Optional trap on misaligned redirect: MISALIGN_TRAP_EN.
module imem_fetch_ctrl
    import rv32i_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] instruction_memory_address,
    input  logic [31:0]       instruction_memory_data,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [31:0]       fetch_instr,
    output logic [31:0]       fetch_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              fetch_misalign
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_state_e   state, state_nxt;
    logic [31:0]    pc, pc_nxt;
    fetch_entry_t   fifo_head;
    fetch_entry_t   hold_q;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PTR_W:0] fifo_count;
    logic           pop;
    logic           push;
    logic           redirect_bad;
    logic           trap_entry;

`ifdef MISALIGN_TRAP_EN
    assign redirect_bad   = is_misaligned(redirect_pc);
    assign fetch_misalign = (state == S_TRAP);
`else
    assign redirect_bad   = 1'b0;
`endif

    assign instruction_memory_address = pc[ADDR_W+1:2];

    assign fetch_valid = (fifo_count != '0);
    assign pop         = fetch_valid & fetch_ready;
    assign push        = (state == S_FETCH) & ~redirect_valid & (~fifo_full | pop);
    assign trap_entry  = redirect_valid & redirect_bad & (state != S_TRAP);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry ('{pc: pc, instr: instruction_memory_data}),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // NOTE: defaults at the top of always_comb keep every path assigned,
    // so no latch is inferred for state_nxt or pc_nxt.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_FETCH;
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_BOOT;
        endcase
        if (push) pc_nxt = pc + 32'd4;
        // Redirect outranks everything; a bad target parks the fetcher.
        if (redirect_valid && state != S_TRAP) begin
            if (redirect_bad) state_nxt = S_TRAP;
            else              pc_nxt    = redirect_pc & ~32'h3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Last presented head, shown while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (trap_entry) begin
            hold_q.pc <= redirect_pc;
        end else if (!fifo_empty) begin
            hold_q <= fifo_head;
        end
    end

    assign fetch_pc    = fifo_empty ? hold_q.pc    : fifo_head.pc;
    assign fetch_instr = fifo_empty ? hold_q.instr : fifo_head.instr;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl (ADDR_W=12, DEPTH=2).
// ROM model returns word_address*3; define MISALIGN_TRAP_EN for the trap case.
module tb_imem_fetch_ctrl;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [31:0]       fetch_instr;
    logic [31:0]       fetch_pc;
`ifdef MISALIGN_TRAP_EN
    logic              fetch_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'(imem_addr) * 32'd3;

    imem_fetch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .redirect_valid             (redirect_valid),
        .redirect_pc                (redirect_pc),
        .instruction_memory_address (imem_addr),
        .instruction_memory_data    (imem_data),
        .fetch_valid                (fetch_valid),
        .fetch_ready                (fetch_ready),
        .fetch_instr                (fetch_instr),
        .fetch_pc                   (fetch_pc)
`ifdef MISALIGN_TRAP_EN
        ,
        .fetch_misalign             (fetch_misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected head for a given PC; instr is hand-derived from the ROM model.
    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        check({tag, "_pc"}, fetch_pc, pc);
        check({tag, "_instr"}, fetch_instr, instr);
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        #12;
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_pc",    fetch_pc,    32'h0);
        check("rst_instr", fetch_instr, 32'h0);
        check("rst_addr",  32'(imem_addr), 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: boot cycle, then one entry per cycle
        step();
        check("boot_valid", 32'(fetch_valid), 32'd0);
        step(); expect_head("s0", 32'h0, 32'd0);
        step(); expect_head("s1", 32'h4, 32'd3);
        step(); expect_head("s2", 32'h8, 32'd6);

        // Back-pressure: FIFO fills, address frozen on next PC (0x10)
        fetch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_head("stall", 32'h8, 32'd6);
            check("stall_addr", 32'(imem_addr), 32'd4);
        end
        fetch_ready = 1'b1;
        step(); expect_head("r0", 32'hC,  32'd9);
        step(); expect_head("r1", 32'h10, 32'd12);
        step(); expect_head("r2", 32'h14, 32'd15);

        // Redirect with a simultaneous pop: popped entry dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("rd_flush_valid", 32'(fetch_valid), 32'd0);
        check("rd_hold_pc", fetch_pc, 32'h14);
        check("rd_addr", 32'(imem_addr), 32'h40);
        step(); expect_head("rd_tgt", 32'h100, 32'hC0);

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        check("b2b_valid", 32'(fetch_valid), 32'd0);
        step(); expect_head("b2b_tgt", 32'h300, 32'h240);

        // Address wrap at the top of the 12-bit word space
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FFC;
        step();
        redirect_valid = 1'b0;
        step(); expect_head("wrap0", 32'h3FFC, 32'h2FFD);
        check("wrap_addr", 32'(imem_addr), 32'h0);
        step(); expect_head("wrap1", 32'h4000, 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        check("trap_misalign", 32'(fetch_misalign), 32'd1);
        check("trap_valid", 32'(fetch_valid), 32'd0);
        check("trap_pc", fetch_pc, 32'h102);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        check("trap_sticky", 32'(fetch_misalign), 32'd1);
        check("trap_valid2", 32'(fetch_valid), 32'd0);
        check("trap_pc2", fetch_pc, 32'h102);
`else
        step(); expect_head("mis_trunc", 32'h100, 32'hC0);
        step(); expect_head("mis_next", 32'h104, 32'hC3);
`endif

        // Asynchronous reset mid-stream
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(fetch_valid), 32'd0);
        check("arst_pc",    fetch_pc,    32'h0);
        check("arst_instr", fetch_instr, 32'h0);
        check("arst_addr",  32'(imem_addr), 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("arst_misalign", 32'(fetch_misalign), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_boot_valid", 32'(fetch_valid), 32'd0);
        step(); expect_head("arst_s0", 32'h0, 32'd0);
        step(); expect_head("arst_s1", 32'h4, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
